instr_seq: RTL

- Multi-cycle instruction sequencer for the MSP430 core; sits between instr_dec and the datapath muxes.
- Walks each instruction through fetch, source extension word, source operand read, destination extension word, destination read, execute and memory write-back.
- Drives MAB source select, PC mux control, register/memory write strobes and operand latch enables.
- Stalls on a memory ready handshake.

---
 rtl/instr_seq_pkg.sv | 61 ++++++
 rtl/instr_seq_if.sv | 36 +++
 rtl/instr_seq_opnd_class.sv | 41 ++++
 rtl/instr_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the MSP430 instruction sequencer:
//   - sequencer state encodings (FETCH is encoding 0)
//   - operand addressing classes produced by instr_seq_opnd_class
//   - MAB source select, PC mux and instruction format codes
//   - small helpers that answer "what does this operand class need"
package instr_seq_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_SRC_EXT = 4'd1,
        ST_SRC_RD  = 4'd2,
        ST_DST_EXT = 4'd3,
        ST_DST_RD  = 4'd4,
        ST_EXEC    = 4'd5,
        ST_DST_WR  = 4'd6,
        ST_HALT    = 4'd7
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_REG   = 3'd0,
        CLS_CONST = 3'd1,
        CLS_IMM   = 3'd2,
        CLS_IDX   = 3'd3,
        CLS_ABS   = 3'd4,
        CLS_IND   = 3'd5,
        CLS_AINC  = 3'd6
    } opnd_class_e;

    // MAB source select codes
    localparam logic [2:0] MAB_PC   = 3'd0;
    localparam logic [2:0] MAB_CALC = 3'd2;
    localparam logic [2:0] MAB_SOUT = 3'd3;
    localparam logic [2:0] MAB_EA   = 3'd5;

    // PC mux codes
    localparam logic [1:0] MPC_HOLD = 2'd0;
    localparam logic [1:0] MPC_INC  = 2'd1;
    localparam logic [1:0] MPC_OFFS = 2'd3;

    // Instruction formats from instr_dec
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_II  = 2'd2;
    localparam logic [1:0] FMT_JMP = 2'd3;

    // Operand is followed by an extension word in the instruction stream.
    function automatic logic cls_needs_ext(input opnd_class_e cls);
        return (cls == CLS_IMM) || (cls == CLS_IDX) || (cls == CLS_ABS);
    endfunction

    // Operand value comes from a data memory read.
    function automatic logic cls_reads_mem(input opnd_class_e cls);
        return (cls == CLS_IDX) || (cls == CLS_ABS) ||
               (cls == CLS_IND) || (cls == CLS_AINC);
    endfunction

    // Extension word supplies an address offset (as opposed to the operand itself).
    function automatic logic cls_uses_calc(input opnd_class_e cls);
        return (cls == CLS_IDX) || (cls == CLS_ABS);
    endfunction

endpackage

// File: rtl/instr_seq_if.sv
// Memory-side handshake and datapath strobe bundle of the sequencer.
//   mem_rdy   : memory access completes this cycle (slave -> master)
//   mab_sel   : MAB source select (0=PC, 2=CALC, 3=Sout, 5=EA latch)
//   mpc       : PC mux (0=hold, 1=PC+2, 3=PC+offset)
//   mem_re    : memory read strobe
//   mem_we    : memory write strobe
//   ir_load   : latch MDB into IR
//   ext_load  : latch extension word
//   opnd_load : latch memory operand
//   ea_load   : latch effective address
// master = sequencer, slave = memory/datapath side.
interface instr_seq_if;

    logic       mem_rdy;
    logic [2:0] mab_sel;
    logic [1:0] mpc;
    logic       mem_re;
    logic       mem_we;
    logic       ir_load;
    logic       ext_load;
    logic       opnd_load;
    logic       ea_load;

    modport master (
        input  mem_rdy,
        output mab_sel, mpc, mem_re, mem_we,
        output ir_load, ext_load, opnd_load, ea_load
    );

    modport slave (
        output mem_rdy,
        input  mab_sel, mpc, mem_re, mem_we,
        input  ir_load, ext_load, opnd_load, ea_load
    );

endinterface

// File: rtl/instr_seq_opnd_class.sv
// Combinational operand addressing classifier.
//   fmt  : instruction format (1=I, 2=II, 3=jump)
//   as   : source addressing mode
//   sreg : source register field (operand register for format I)
//   dreg : destination register field (operand register for format II)
//   cls  : REG / CONST / IMM / IDX / ABS / IND / AINC
// R2 and R3 double as constant generators, which is why they are
// checked before the generic register-mode decode.
module instr_seq_opnd_class
    import instr_seq_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [1:0]  as,
    input  logic [3:0]  sreg,
    input  logic [3:0]  dreg,
    output opnd_class_e cls
);

    logic [3:0] opr;

    assign opr = (fmt == FMT_I) ? sreg : dreg;

    always_comb begin
        cls = CLS_REG;
        if ((opr == 4'd3) || ((opr == 4'd2) && as[1])) begin
            cls = CLS_CONST;
        end else if ((opr == 4'd2) && (as == 2'b01)) begin
            cls = CLS_ABS;
        end else if ((opr == 4'd0) && (as == 2'b11)) begin
            cls = CLS_IMM;
        end else begin
            case (as)
                2'b01:   cls = CLS_IDX;
                2'b10:   cls = CLS_IND;
                2'b11:   cls = CLS_AINC;
                default: cls = CLS_REG;
            endcase
        end
    end

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle MSP430 instruction sequencer between instr_dec and the
// datapath muxes. Walks an instruction through fetch, source extension,
// source read, destination extension, destination read, execute and
// memory write-back, stalling every memory state on mem_rdy.
//   clk, rst    : core clock, synchronous active-high reset
//   bus         : memory handshake / datapath strobes (instr_seq_if.master)
//   fmt, as, ad : format, source mode, destination mode from instr_dec
//   sreg, dreg  : register fields
//   bw          : byte op (consumed by the datapath, not by sequencing)
//   wb          : op writes its result
//   illegal     : decoder found no valid op
//   cond_true   : jump condition satisfied
//   state       : current state
//   reg_we      : register file write
//   autoinc_we  : write Rn+1/+2
//   exec_en     : ALU result and SR update valid
//   halted      : in HALT
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    instr_seq_if.master bus,
    input  logic [1:0]  fmt,
    input  logic [1:0]  as,
    input  logic        ad,
    input  logic [3:0]  sreg,
    input  logic [3:0]  dreg,
    input  logic        bw,
    input  logic        wb,
    input  logic        illegal,
    input  logic        cond_true,
    output logic [3:0]  state,
    output logic        reg_we,
    output logic        autoinc_we,
    output logic        exec_en,
    output logic        halted
);

    seq_state_e  state_q;
    seq_state_e  state_d;
    seq_state_e  dst_path;
    opnd_class_e cls;
    logic        mem_dst;
    logic        unused_bw;

    assign unused_bw = bw;

    instr_seq_opnd_class u_opnd_class (
        .fmt  (fmt),
        .as   (as),
        .sreg (sreg),
        .dreg (dreg),
        .cls  (cls)
    );

    // After the source phase: format I with memory destination fetches it.
    assign dst_path = ((fmt == FMT_I) && ad) ? ST_DST_EXT : ST_EXEC;

    // Result goes back to memory: indexed destination (format I) or the
    // single operand of format II when it lives in memory.
    assign mem_dst = ((fmt == FMT_I) && ad) ||
                     ((fmt == FMT_II) && cls_reads_mem(cls));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset is also applied here so that strobes are quiet during the reset
    // cycle itself, not only after the state register has been cleared.
    always_comb begin
        state_d       = state_q;
        bus.mab_sel   = MAB_PC;
        bus.mpc       = MPC_HOLD;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.ir_load   = 1'b0;
        bus.ext_load  = 1'b0;
        bus.opnd_load = 1'b0;
        bus.ea_load   = 1'b0;
        reg_we        = 1'b0;
        autoinc_we    = 1'b0;
        exec_en       = 1'b0;
        halted        = 1'b0;

        if (rst) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_re = 1'b1;
                    if (bus.mem_rdy) begin
                        bus.ir_load = 1'b1;
                        bus.mpc     = MPC_INC;
                        if (fmt == FMT_JMP) begin
                            state_d = ST_EXEC;
                        end else if (illegal) begin
                            state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
                        end else if (cls_needs_ext(cls)) begin
                            state_d = ST_SRC_EXT;
                        end else if (cls_reads_mem(cls)) begin
                            state_d = ST_SRC_RD;
                        end else begin
                            state_d = dst_path;
                        end
                    end
                end

                ST_SRC_EXT: begin
                    bus.mem_re = 1'b1;
                    if (bus.mem_rdy) begin
                        bus.ext_load = 1'b1;
                        bus.mpc      = MPC_INC;
                        state_d      = cls_uses_calc(cls) ? ST_SRC_RD : dst_path;
                    end
                end

                ST_SRC_RD: begin
                    bus.mem_re  = 1'b1;
                    bus.mab_sel = cls_uses_calc(cls) ? MAB_CALC : MAB_SOUT;
                    if (bus.mem_rdy) begin
                        bus.opnd_load = 1'b1;
                        bus.ea_load   = 1'b1;
                        autoinc_we    = (cls == CLS_AINC);
                        state_d       = dst_path;
                    end
                end

                ST_DST_EXT: begin
                    bus.mem_re = 1'b1;
                    if (bus.mem_rdy) begin
                        bus.ext_load = 1'b1;
                        bus.mpc      = MPC_INC;
                        state_d      = ST_DST_RD;
                    end
                end

                ST_DST_RD: begin
                    bus.mem_re  = 1'b1;
                    bus.mab_sel = MAB_CALC;
                    if (bus.mem_rdy) begin
                        bus.opnd_load = 1'b1;
                        bus.ea_load   = 1'b1;
                        state_d       = ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    exec_en = 1'b1;
                    if ((fmt == FMT_JMP) && cond_true) begin
                        bus.mpc = MPC_OFFS;
                    end
                    if (wb && mem_dst) begin
                        state_d = ST_DST_WR;
                    end else begin
                        reg_we  = wb;
                        state_d = ST_FETCH;
                    end
                end

                ST_DST_WR: begin
                    bus.mem_we  = 1'b1;
                    bus.mab_sel = MAB_EA;
                    if (bus.mem_rdy) begin
                        state_d = ST_FETCH;
                    end
                end

                ST_HALT: begin
                    halted = 1'b1;
                end

                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    assign state = rst ? ST_FETCH : state_q;

endmodule
